// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: synchronizes the codec bit clock, frame clock and data, deserializes 16-bit left/right words and presents each complete pair through a valid/ready holding register.
// Optional sticky overrun output when compiled with `define I2S_ADC_RX_OVERRUN_EN.
module i2s_adc_rx #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init_done,
  input  logic                     AUD_BCLK,
  input  logic                     AUD_ADCLRCK,
  input  logic                     AUD_ADCDAT,
  output logic signed [DATA_W-1:0] sample_l,
  output logic signed [DATA_W-1:0] sample_r,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef I2S_ADC_RX_OVERRUN_EN
  ,
  output logic                     overrun
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  logic                     r_bclk_p0, r_bclk_p1, r_bclk_p2;
  logic                     r_lrck_p0, r_lrck_p1;
  logic                     r_dat_p0, r_dat_p1;
  logic                     r_lrck_prev;
  state_t                   r_state;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic signed [DATA_W-1:0] r_shift_l;
  logic signed [DATA_W-1:0] r_shift_r;
  logic signed [DATA_W-1:0] r_sample_l;
  logic signed [DATA_W-1:0] r_sample_r;
  logic                     r_out_valid;

  logic                     w_bclk_rise;
  logic                     w_lrck;
  logic                     w_dat;
  logic                     w_offer;
  logic signed [DATA_W-1:0] w_new_r;

  // Stage p0/p1: two-flop synchronizers; p2 is the BCLK history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_p0 <= 1'b0;
      r_bclk_p1 <= 1'b0;
      r_bclk_p2 <= 1'b0;
      r_lrck_p0 <= 1'b0;
      r_lrck_p1 <= 1'b0;
      r_dat_p0  <= 1'b0;
      r_dat_p1  <= 1'b0;
    end else begin
      r_bclk_p0 <= AUD_BCLK;
      r_bclk_p1 <= r_bclk_p0;
      r_bclk_p2 <= r_bclk_p1;
      r_lrck_p0 <= AUD_ADCLRCK;
      r_lrck_p1 <= r_lrck_p0;
      r_dat_p0  <= AUD_ADCDAT;
      r_dat_p1  <= r_dat_p0;
    end
  end

  assign w_bclk_rise = r_bclk_p1 & ~r_bclk_p2;
  assign w_lrck      = r_lrck_p1;
  assign w_dat       = r_dat_p1;

  // The last right bit completes the pair; RIGHT is only reachable with a full left word
  assign w_offer = init_done && (r_state == ST_RIGHT) && w_bclk_rise && w_lrck
                   && (r_bit_cnt == CNT_LAST);
  assign w_new_r = {r_shift_r[DATA_W-2:0], w_dat};

  // Stage p3: frame FSM and deserializers, advancing only on detected BCLK rising edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift_l   <= '0;
      r_shift_r   <= '0;
      r_lrck_prev <= 1'b0;
    end else begin
      if (w_bclk_rise) begin
        r_lrck_prev <= w_lrck;
      end
      if (!init_done) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_shift_l <= '0;
        r_shift_r <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (w_bclk_rise && !w_lrck && r_lrck_prev) begin
              r_state   <= ST_LEFT;
              r_bit_cnt <= '0;
            end
          end
          ST_LEFT: begin
            if (w_bclk_rise) begin
              if (w_lrck) begin
                r_state   <= (r_bit_cnt == CNT_FULL) ? ST_RIGHT : ST_SYNC;
                r_bit_cnt <= '0;
              end else if (r_bit_cnt < CNT_FULL) begin
                r_shift_l <= {r_shift_l[DATA_W-2:0], w_dat};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_RIGHT: begin
            if (w_bclk_rise) begin
              if (!w_lrck) begin
                r_state   <= (r_bit_cnt == CNT_FULL) ? ST_LEFT : ST_SYNC;
                r_bit_cnt <= '0;
              end else if (r_bit_cnt < CNT_FULL) begin
                r_shift_r <= w_new_r;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Stage p4: holding register; a pair offered while a held pair is unaccepted is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_l  <= '0;
      r_sample_r  <= '0;
      r_out_valid <= 1'b0;
    end else if (!init_done) begin
      r_out_valid <= 1'b0;
    end else if (w_offer && (!r_out_valid || out_ready)) begin
      r_sample_l  <= r_shift_l;
      r_sample_r  <= w_new_r;
      r_out_valid <= 1'b1;
    end else if (!w_offer && r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef I2S_ADC_RX_OVERRUN_EN
  logic r_overrun;
  logic w_drop;

  assign w_drop = w_offer && r_out_valid && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

  assign sample_l  = r_sample_l;
  assign sample_r  = r_sample_r;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed testbench for i2s_adc_rx: drives I2S frames at BCLK = clk/16 and checks captured pairs and handshake behaviour.
// Overrun checks are included when I2S_ADC_RX_OVERRUN_EN is defined.
module tb_i2s_adc_rx;

  logic               clk;
  logic               reset;
  logic               init_done;
  logic               AUD_BCLK;
  logic               AUD_ADCLRCK;
  logic               AUD_ADCDAT;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic               out_valid;
  logic               out_ready;
`ifdef I2S_ADC_RX_OVERRUN_EN
  logic               overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  logic [15:0] acc_l = '0;
  logic [15:0] acc_r = '0;

  i2s_adc_rx #(.DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .init_done   (init_done),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef I2S_ADC_RX_OVERRUN_EN
    ,
    .overrun     (overrun)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Records every accepted pair
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_l   <= sample_l;
      acc_r   <= sample_r;
    end
  end

  // One BCLK period = 16 clk cycles; LRCK/DAT change with the falling edge
  task automatic bclk_cycle(input logic l, input logic d);
    @(negedge clk);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = l;
    AUD_ADCDAT  = d;
    repeat (8) @(negedge clk);
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    bclk_cycle(1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) bclk_cycle(1'b0, l[i]);
    bclk_cycle(1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) bclk_cycle(1'b1, r[i]);
  endtask

  task automatic test_reset();
    #5;
    n_checks++;
    if (sample_l !== 16'h0000) begin n_fail++; $display("FAIL reset_sample_l: got %h expected 0000", sample_l); end
    n_checks++;
    if (sample_r !== 16'h0000) begin n_fail++; $display("FAIL reset_sample_r: got %h expected 0000", sample_r); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
`ifdef I2S_ADC_RX_OVERRUN_EN
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int base;
    init_done = 1'b1;
    out_ready = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 17; i++) bclk_cycle(1'b1, 1'b0);
    send_frame(16'h1234, 16'hABCD);
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_cnt - base !== 1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", acc_cnt - base); end
    n_checks++;
    if (acc_l !== 16'h1234) begin n_fail++; $display("FAIL basic_l: got %h expected 1234", acc_l); end
    n_checks++;
    if (acc_r !== 16'hABCD) begin n_fail++; $display("FAIL basic_r: got %h expected abcd", acc_r); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_cleared: got %b expected 0", out_valid); end
  endtask

  task automatic test_mid_right();
    int base;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 8; i++) bclk_cycle(1'b1, 1'b1);
    send_frame(16'h4321, 16'h8765);
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_cnt - base !== 1) begin n_fail++; $display("FAIL midright_count: got %0d expected 1", acc_cnt - base); end
    n_checks++;
    if (acc_l !== 16'h4321) begin n_fail++; $display("FAIL midright_l: got %h expected 4321", acc_l); end
    n_checks++;
    if (acc_r !== 16'h8765) begin n_fail++; $display("FAIL midright_r: got %h expected 8765", acc_r); end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send_frame(16'h0001, 16'h0002);
    send_frame(16'h0003, 16'h0004);
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (sample_l !== 16'h0001) begin n_fail++; $display("FAIL hold_l: got %h expected 0001", sample_l); end
    n_checks++;
    if (sample_r !== 16'h0002) begin n_fail++; $display("FAIL hold_r: got %h expected 0002", sample_r); end
`ifdef I2S_ADC_RX_OVERRUN_EN
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL hold_overrun: got %b expected 1", overrun); end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL accept_clears_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (sample_l !== 16'h0001 || sample_r !== 16'h0002) begin
      n_fail++; $display("FAIL accept_keeps_samples: got %h/%h expected 0001/0002", sample_l, sample_r);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_early_lrck();
    int base;
    base = acc_cnt;
    bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) bclk_cycle(1'b0, 1'b1);
    bclk_cycle(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) bclk_cycle(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_cnt - base !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_not_presented: got count %0d valid %b expected 0 0", acc_cnt - base, out_valid);
    end
    n_checks++;
    if (sample_l !== 16'h0001) begin n_fail++; $display("FAIL early_sample_kept: got %h expected 0001", sample_l); end
    send_frame(16'h7FFF, 16'h8000);
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_cnt - base !== 1) begin n_fail++; $display("FAIL early_next_count: got %0d expected 1", acc_cnt - base); end
    n_checks++;
    if (acc_l !== 16'h7FFF) begin n_fail++; $display("FAIL early_next_l: got %h expected 7fff", acc_l); end
    n_checks++;
    if (acc_r !== 16'h8000) begin n_fail++; $display("FAIL early_next_r: got %h expected 8000", acc_r); end
  endtask

  task automatic test_init_drop();
    int base;
    logic [15:0] wl;
    logic [15:0] wr;
    wl = 16'hDEAD;
    wr = 16'hBEEF;
    out_ready = 1'b0;
    send_frame(16'h0A0A, 16'h0B0B);
    bclk_cycle(1'b0, 1'b0);
    for (int i = 15; i >= 8; i--) bclk_cycle(1'b0, wl[i]);
    @(negedge clk);
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL initdrop_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (sample_l !== 16'h0A0A || sample_r !== 16'h0B0B) begin
      n_fail++; $display("FAIL initdrop_samples_kept: got %h/%h expected 0a0a/0b0b", sample_l, sample_r);
    end
    init_done = 1'b1;
    out_ready = 1'b1;
    base = acc_cnt;
    for (int i = 7; i >= 0; i--) bclk_cycle(1'b0, wl[i]);
    bclk_cycle(1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) bclk_cycle(1'b1, wr[i]);
    send_frame(16'h0F0F, 16'hF0F0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_cnt - base !== 1) begin n_fail++; $display("FAIL initdrop_count: got %0d expected 1", acc_cnt - base); end
    n_checks++;
    if (acc_l !== 16'h0F0F || acc_r !== 16'hF0F0) begin
      n_fail++; $display("FAIL initdrop_resume: got %h/%h expected 0f0f/f0f0", acc_l, acc_r);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    w = 16'hC3C3;
    out_ready = 1'b0;
    send_frame(16'h1357, 16'h2468);
    n_checks++;
    if (out_valid !== 1'b1 || sample_l !== 16'h1357) begin
      n_fail++; $display("FAIL resetmid_pre: got valid %b l %h expected 1 1357", out_valid, sample_l);
    end
    bclk_cycle(1'b0, 1'b0);
    for (int i = 15; i >= 11; i--) bclk_cycle(1'b0, w[i]);
    #3;
    reset = 1'b0;
    #2;
    n_checks++;
    if (sample_l !== 16'h0000 || sample_r !== 16'h0000) begin
      n_fail++; $display("FAIL resetmid_samples: got %h/%h expected 0000/0000", sample_l, sample_r);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resetmid_valid: got %b expected 0", out_valid); end
`ifdef I2S_ADC_RX_OVERRUN_EN
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL resetmid_overrun: got %b expected 0", overrun); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 10; i >= 0; i--) bclk_cycle(1'b0, w[i]);
    bclk_cycle(1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) bclk_cycle(1'b1, ~w[i]);
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL resetmid_partial_ignored: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l;
    logic [15:0] r;
    l = 16'h5555;
    r = 16'hAAAA;
    out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    n_checks++;
    if (out_valid !== 1'b1 || sample_l !== 16'h1111 || sample_r !== 16'h2222) begin
      n_fail++; $display("FAIL b2b_first_held: got %b %h/%h expected 1 1111/2222", out_valid, sample_l, sample_r);
    end
    bclk_cycle(1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) bclk_cycle(1'b0, l[i]);
    bclk_cycle(1'b1, 1'b0);
    for (int i = 15; i >= 1; i--) bclk_cycle(1'b1, r[i]);
    @(negedge clk);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b1;
    AUD_ADCDAT  = r[0];
    repeat (8) @(negedge clk);
    AUD_BCLK = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (sample_l !== 16'h5555 || sample_r !== 16'hAAAA) begin
      n_fail++; $display("FAIL b2b_new_pair: got %h/%h expected 5555/aaaa", sample_l, sample_r);
    end
`ifdef I2S_ADC_RX_OVERRUN_EN
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
`endif
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || sample_l !== 16'h5555) begin
      n_fail++; $display("FAIL b2b_stable: got %b %h expected 1 5555", out_valid, sample_l);
    end
  endtask

  initial begin
    reset       = 1'b0;
    init_done   = 1'b0;
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT  = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_mid_right();
    test_hold();
    test_early_lrck();
    test_init_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
